multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle controller of the RV32I datapath.
- Moore FSM sequences each instruction over 3–5 cycles and drives every datapath mux, enable and ALU control from state plus the latched opcode fields.
- Adds the full RV32I branch set, LUI, AUIPC, JALR, a memory ready handshake with timeout, and illegal-instruction trap.

Parameters:
- ALUCTRL_W, 4, width of ALUControl.
- IMMSRC_W, 3, width of ImmSrc.
- MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before trapping; range 1–255.
- WAITCNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode, from the instruction register.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU result == 0.
- Lt  in  1  signed rs1<rs2, valid in BRANCH.
- Ltu  in  1  unsigned rs1<rs2, valid in BRANCH.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  store enable, qualifies mem_req.
- IRWrite  out  1  load instruction register and OldPC.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=Result.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=4.
- ResultSrc  out  2  Result select: 00=ALUOut, 01=ReadData, 10=ALUResult.
- ImmSrc  out  IMMSRC_W  immediate type: 000=I, 001=S, 010=B, 011=J, 100=U.
- RegWrite  out  1  register file write enable.
- ALUControl  out  ALUCTRL_W  ALU operation code.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  fault cause: 01=illegal, 10=memory timeout.

Behaviour:
- Reset (reset_n=0, asynchronous): state=FETCH, wait counter=0, trap=0, trap_cause=00. All enables (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) forced 0 while reset is asserted.
- ALUControl encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra, 1010 passB.
- In EXECR, funct7b5 selects sub/sra. In EXECI, funct7b5 applies only to srai; addi never subtracts.
- Non-listed outputs default to 0 / 00.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite and PCWrite assert only in the cycle mem_ready=1, then go to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add, precomputing the branch target.
  - lw/sw → MEMADR; R-type → EXECR; I-ALU → EXECI.
  - beq/bne/blt/bge/bltu/bgeu → BRANCH; jal → JAL; jalr → JALR.
  - lui → LUI; auipc → AUIPC.
  - Any other op or funct3 → TRAP with cause 01.
- MEMADR: rs1+imm (ImmSrc I for load, S for store). Next state is MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, AdrSrc=1. On mem_ready → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready → FETCH.
- EXECR / EXECI → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: rs1−rs2, ResultSrc=00. PCWrite = taken, where taken is:
  - beq: Zero; bne: !Zero.
  - blt: Lt; bge: !Lt.
  - bltu: Ltu; bgeu: !Ltu.
  - Then → FETCH.
- JAL: OldPC+4 into ALUOut, PCWrite with ResultSrc=00 (target from DECODE) → ALUWB.
- JALR: two cycles.
  - Cycle 1: rs1+imm, PCWrite with ResultSrc=10.
  - Cycle 2: OldPC+4 → ALUWB.
  - The register file read of rs1 precedes the write, so rd==rs1 is safe.
- LUI: zero+imm(U), passB → ALUWB.
- AUIPC: OldPC+imm(U) → ALUWB.
- Memory wait and timeout:
  - The wait counter clears on entering any memory state and increments each cycle mem_ready=0.
  - Reaching MEM_TIMEOUT → TRAP with cause 10.
  - mem_ready outside memory states is ignored.
- TRAP: all enables 0, absorbing until reset. trap and trap_cause hold their values.
- Reset mid-instruction aborts the instruction: no partial PC or register write after reset release.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[63:0] and instret_cnt[63:0], both reset to 0.
  - cycle_cnt increments every non-reset cycle except in TRAP.
  - instret_cnt increments on each transition into FETCH from a non-FETCH, non-TRAP state.
  - Both counters wrap modulo 2^64.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings;
  - trap cause codes.
- One sub-module, mc_alu_decoder: combinational; inputs state class, funct3, funct7b5, op[5]; output ALUControl.
- Next-state logic and the wait/timeout counter stay in the top module.

Test Plan:
- add x3,x1,x2 with mem_ready=1 in the 2nd FETCH cycle → 5 cycles; IRWrite and PCWrite pulse once; ALUControl=0001 only for sub; RegWrite in ALUWB.
- lw with mem_ready delayed 3 cycles in MEMREAD → MEMREAD held 4 cycles, then RegWrite=1, ResultSrc=01.
- bge with Lt=0 → PCWrite=1 in BRANCH; with Lt=1 → PCWrite=0. Repeat for bltu/bgeu with Ltu.
- op=0000000 → TRAP, trap=1, trap_cause=01, no further enables across 20 cycles; reset_n pulse → FETCH.
- mem_ready held 0 in FETCH for 15 cycles → TRAP, cause 10.
- reset_n low mid-MEMWRITE → MemWrite drops asynchronously; after release, FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes,
// datapath mux selects, ALU operation codes and trap causes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_e;

    // Coarse ALU intent per state; the decoder refines CLS_FUNC from funct3/funct7b5.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_FUNC,
        CLS_PASSB
    } alu_cls_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_MEMTO   = 2'b10;

    // States that wait on mem_ready and therefore run the timeout counter.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decode: the state class selects a fixed op, or defers to
// funct3/funct7b5 for register and immediate arithmetic.
module mc_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_cls_e   cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (cls_i)
            CLS_SUB:   alu_ctrl_o = ALU_SUB;
            CLS_PASSB: alu_ctrl_o = ALU_PASSB;
            CLS_FUNC: begin
                case (funct3_i)
                    // op5 separates R-type from I-type, so addi never subtracts
                    3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore multicycle control FSM for the RV32I datapath with memory-ready timeout
// and sticky trap. Define PERF_CNT_EN to add cycle/instret counters.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int IMMSRC_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int WAITCNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [IMMSRC_W-1:0]  ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 trap,
    output logic [1:0]           trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]          cycle_cnt,
    output logic [63:0]          instret_cnt
`endif
);

    state_e               state_q, state_d, dec_state;
    logic [WAITCNT_W-1:0] waitcnt_q, waitcnt_d;
    logic                 trap_q, trap_d;
    logic [1:0]           cause_q, cause_d;
    logic                 taken;

    logic       mem_req_c, memwrite_c, irwrite_c, pcwrite_c, regwrite_c, adrsrc_c;
    logic [1:0] srca_c, srcb_c, ressrc_c;
    logic [2:0] immsrc_c;
    alu_cls_e   alu_cls;
    logic [3:0] alu_ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            waitcnt_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= TRAP_NONE;
        end else begin
            state_q   <= state_d;
            waitcnt_q <= waitcnt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        dec_state = S_TRAP;
        case (op)
            OP_LOAD:   if (funct3 == 3'b010) dec_state = S_MEMADR;
            OP_STORE:  if (funct3 == 3'b010) dec_state = S_MEMADR;
            OP_RTYPE:  dec_state = S_EXECR;
            OP_ITYPE:  dec_state = S_EXECI;
            OP_BRANCH: if (funct3[2:1] != 2'b01) dec_state = S_BRANCH;
            OP_JAL:    dec_state = S_JAL;
            OP_JALR:   if (funct3 == 3'b000) dec_state = S_JALR1;
            OP_LUI:    dec_state = S_LUI;
            OP_AUIPC:  dec_state = S_AUIPC;
            default:   dec_state = S_TRAP;
        endcase
    end

    // funct3[0] inverts the base condition: beq/bne, blt/bge, bltu/bgeu.
    always_comb begin
        case (funct3[2:1])
            2'b00:   taken = Zero;
            2'b10:   taken = Lt;
            2'b11:   taken = Ltu;
            default: taken = 1'b0;
        endcase
        taken = taken ^ funct3[0];
    end

    always_comb begin
        state_d    = state_q;
        waitcnt_d  = '0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        mem_req_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        pcwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        adrsrc_c   = 1'b0;
        srca_c     = SRCA_PC;
        srcb_c     = SRCB_RS2;
        ressrc_c   = RES_ALUOUT;
        immsrc_c   = IMM_I;
        alu_cls    = CLS_ADD;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                srcb_c    = SRCB_FOUR;
                ressrc_c  = RES_ALURES;
                if (mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                srca_c   = SRCA_OLDPC;
                srcb_c   = SRCB_IMM;
                immsrc_c = IMM_B;
                state_d  = dec_state;
                if (dec_state == S_TRAP) cause_d = TRAP_ILLEGAL;
            end
            S_MEMADR: begin
                srca_c   = SRCA_RS1;
                srcb_c   = SRCB_IMM;
                immsrc_c = op[5] ? IMM_S : IMM_I;
                state_d  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adrsrc_c  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ressrc_c   = RES_RDATA;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c  = 1'b1;
                memwrite_c = 1'b1;
                adrsrc_c   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                srca_c  = SRCA_RS1;
                alu_cls = CLS_FUNC;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                srca_c  = SRCA_RS1;
                srcb_c  = SRCB_IMM;
                alu_cls = CLS_FUNC;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                srca_c    = SRCA_RS1;
                alu_cls   = CLS_SUB;
                pcwrite_c = taken;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // ALUOut still holds the target computed in DECODE
                srca_c    = SRCA_OLDPC;
                srcb_c    = SRCB_FOUR;
                pcwrite_c = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR1: begin
                srca_c    = SRCA_RS1;
                srcb_c    = SRCB_IMM;
                ressrc_c  = RES_ALURES;
                pcwrite_c = 1'b1;
                state_d   = S_JALR2;
            end
            S_JALR2: begin
                srca_c  = SRCA_OLDPC;
                srcb_c  = SRCB_FOUR;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                srca_c   = SRCA_ZERO;
                srcb_c   = SRCB_IMM;
                immsrc_c = IMM_U;
                alu_cls  = CLS_PASSB;
                state_d  = S_ALUWB;
            end
            S_AUIPC: begin
                srca_c   = SRCA_OLDPC;
                srcb_c   = SRCB_IMM;
                immsrc_c = IMM_U;
                state_d  = S_ALUWB;
            end
            default: state_d = S_TRAP;
        endcase

        // Counter is zero on entry to every memory state since any other cycle clears it.
        if (is_mem_state(state_q) && !mem_ready) begin
            if (waitcnt_q == WAITCNT_W'(MEM_TIMEOUT - 1)) begin
                state_d = S_TRAP;
                cause_d = TRAP_MEMTO;
            end else begin
                waitcnt_d = waitcnt_q + WAITCNT_W'(1);
            end
        end

        if (state_d == S_TRAP) trap_d = 1'b1;
    end

    mc_alu_decoder u_alu_dec (
        .cls_i      (alu_cls),
        .funct3_i   (funct3),
        .funct7b5_i (funct7b5),
        .op5_i      (op[5]),
        .alu_ctrl_o (alu_ctrl)
    );

    // State resets to FETCH, so enables are gated with reset_n to stay low during reset.
    assign mem_req    = mem_req_c  & reset_n;
    assign MemWrite   = memwrite_c & reset_n;
    assign IRWrite    = irwrite_c  & reset_n;
    assign PCWrite    = pcwrite_c  & reset_n;
    assign RegWrite   = regwrite_c & reset_n;
    assign AdrSrc     = adrsrc_c;
    assign ALUSrcA    = srca_c;
    assign ALUSrcB    = srcb_c;
    assign ResultSrc  = ressrc_c;
    assign ImmSrc     = IMMSRC_W'(immsrc_c);
    assign ALUControl = ALUCTRL_W'(alu_ctrl);
    assign trap       = trap_q;
    assign trap_cause = cause_q;

`ifdef PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
                instret_cnt_q <= instret_cnt_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state-by-state output signatures
// for each instruction class, memory handshake, timeout, illegal trap, reset.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, mem_ready = 1'b0;
    logic       mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, trap;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, trap_cause;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [18:0] sig;
    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready), .mem_req(mem_req),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegWrite, ALUControl}
    assign sig = {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ImmSrc, RegWrite, ALUControl};

    localparam logic [18:0] SIG_FETCH     = {5'b10000, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_FETCH_RDY = {5'b10110, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_FETCH_RST = {5'b00000, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_DECODE    = {5'b00000, 2'b01, 2'b01, 2'b00, 3'b010, 1'b0, 4'h0};
    localparam logic [18:0] SIG_ALUWB     = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 4'h0};
    localparam logic [18:0] SIG_MEMADR_LW = {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_MEMADR_SW = {5'b00000, 2'b10, 2'b01, 2'b00, 3'b001, 1'b0, 4'h0};
    localparam logic [18:0] SIG_MEMREAD   = {5'b10001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_MEMWB     = {5'b00000, 2'b00, 2'b00, 2'b01, 3'b000, 1'b1, 4'h0};
    localparam logic [18:0] SIG_MEMWRITE  = {5'b11001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_JAL       = {5'b00010, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_JALR1     = {5'b00010, 2'b10, 2'b01, 2'b10, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_JALR2     = {5'b00000, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 4'h0};
    localparam logic [18:0] SIG_LUI       = {5'b00000, 2'b11, 2'b01, 2'b00, 3'b100, 1'b0, 4'hA};
    localparam logic [18:0] SIG_AUIPC     = {5'b00000, 2'b01, 2'b01, 2'b00, 3'b100, 1'b0, 4'h0};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in DECODE with mem_ready low.
    task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        #1;
    endtask

    task automatic pulse_reset();
        mem_ready = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sig !== SIG_FETCH_RST) begin errors++; $display("FAIL reset_outputs: got %h exp %h", sig, SIG_FETCH_RST); end
        checks++;
        if ({trap, trap_cause} !== 3'b000) begin errors++; $display("FAIL reset_trap: got %b exp 000", {trap, trap_cause}); end
        mem_ready = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (sig !== SIG_FETCH) begin errors++; $display("FAIL reset_release_fetch: got %h exp %h", sig, SIG_FETCH); end
    endtask

    task automatic test_rtype();
        logic [2:0] f3v [3] = '{3'b000, 3'b000, 3'b111};
        logic       f7v [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] alu [3] = '{4'h0, 4'h1, 4'h2};
        logic [18:0] exp;
        for (int i = 0; i < 3; i++) begin
            op = 7'b0110011; funct3 = f3v[i]; funct7b5 = f7v[i]; mem_ready = 1'b0;
            #1;
            checks++;
            if (sig !== SIG_FETCH) begin errors++; $display("FAIL rtype%0d_fetch_wait: got %h exp %h", i, sig, SIG_FETCH); end
            next_cycle();
            mem_ready = 1'b1;
            #1;
            checks++;
            if (sig !== SIG_FETCH_RDY) begin errors++; $display("FAIL rtype%0d_fetch_ready: got %h exp %h", i, sig, SIG_FETCH_RDY); end
            next_cycle();
            mem_ready = 1'b0;
            #1;
            checks++;
            if (sig !== SIG_DECODE) begin errors++; $display("FAIL rtype%0d_decode: got %h exp %h", i, sig, SIG_DECODE); end
            next_cycle();
            exp = {5'b00000, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, alu[i]};
            checks++;
            if (sig !== exp) begin errors++; $display("FAIL rtype%0d_execr: got %h exp %h", i, sig, exp); end
            next_cycle();
            checks++;
            if (sig !== SIG_ALUWB) begin errors++; $display("FAIL rtype%0d_aluwb: got %h exp %h", i, sig, SIG_ALUWB); end
            next_cycle();
            checks++;
            if (sig !== SIG_FETCH) begin errors++; $display("FAIL rtype%0d_refetch: got %h exp %h", i, sig, SIG_FETCH); end
        end
    endtask

    task automatic test_itype();
        logic [2:0] f3v [4] = '{3'b000, 3'b101, 3'b101, 3'b010};
        logic       f7v [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] alu [4] = '{4'h0, 4'h9, 4'h8, 4'h5};
        logic [18:0] exp;
        for (int i = 0; i < 4; i++) begin
            fetch_decode(7'b0010011, f3v[i], f7v[i]);
            next_cycle();
            exp = {5'b00000, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0, alu[i]};
            checks++;
            if (sig !== exp) begin errors++; $display("FAIL itype%0d_execi: got %h exp %h", i, sig, exp); end
            next_cycle();
            checks++;
            if (sig !== SIG_ALUWB) begin errors++; $display("FAIL itype%0d_aluwb: got %h exp %h", i, sig, SIG_ALUWB); end
            next_cycle();
        end
    endtask

    task automatic test_load();
        fetch_decode(7'b0000011, 3'b010, 1'b0);
        next_cycle();
        checks++;
        if (sig !== SIG_MEMADR_LW) begin errors++; $display("FAIL lw_memadr: got %h exp %h", sig, SIG_MEMADR_LW); end
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            #1;
            checks++;
            if (sig !== SIG_MEMREAD) begin errors++; $display("FAIL lw_memread%0d: got %h exp %h", k, sig, SIG_MEMREAD); end
            next_cycle();
        end
        mem_ready = 1'b0;
        #1;
        checks++;
        if (sig !== SIG_MEMWB) begin errors++; $display("FAIL lw_memwb: got %h exp %h", sig, SIG_MEMWB); end
        next_cycle();
        checks++;
        if (sig !== SIG_FETCH) begin errors++; $display("FAIL lw_refetch: got %h exp %h", sig, SIG_FETCH); end
    endtask

    task automatic test_branch();
        // {funct3, Zero, Lt, Ltu, taken}
        logic [6:0] vec [8] = '{
            {3'b101, 1'b0, 1'b0, 1'b0, 1'b1},  // bge, not less
            {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},  // bge, less
            {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},  // bltu, less
            {3'b110, 1'b0, 1'b1, 1'b0, 1'b0},  // bltu, signed-less only
            {3'b111, 1'b0, 1'b1, 1'b0, 1'b1},  // bgeu, unsigned not less
            {3'b111, 1'b0, 1'b0, 1'b1, 1'b0},  // bgeu, unsigned less
            {3'b000, 1'b1, 1'b0, 1'b0, 1'b1},  // beq, equal
            {3'b001, 1'b1, 1'b0, 1'b0, 1'b0}   // bne, equal
        };
        logic [6:0] v;
        logic [18:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = vec[i];
            Zero = v[3]; Lt = v[2]; Ltu = v[1];
            fetch_decode(7'b1100011, v[6:4], 1'b0);
            next_cycle();
            exp = {3'b000, v[0], 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0, 4'h1};
            checks++;
            if (sig !== exp) begin errors++; $display("FAIL branch%0d: got %h exp %h", i, sig, exp); end
            next_cycle();
            checks++;
            if (sig !== SIG_FETCH) begin errors++; $display("FAIL branch%0d_refetch: got %h exp %h", i, sig, SIG_FETCH); end
        end
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    endtask

    task automatic test_jumps();
        logic [6:0]  ops [4] = '{7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};
        int          len [4] = '{2, 3, 2, 2};
        logic [18:0] seq [4][3];
        seq[0] = '{SIG_JAL,   SIG_ALUWB, SIG_ALUWB};
        seq[1] = '{SIG_JALR1, SIG_JALR2, SIG_ALUWB};
        seq[2] = '{SIG_AUIPC, SIG_ALUWB, SIG_ALUWB};
        seq[3] = '{SIG_LUI,   SIG_ALUWB, SIG_ALUWB};
        for (int j = 0; j < 4; j++) begin
            fetch_decode(ops[j], 3'b000, 1'b0);
            for (int k = 0; k < len[j]; k++) begin
                next_cycle();
                checks++;
                if (sig !== seq[j][k]) begin errors++; $display("FAIL jump%0d_step%0d: got %h exp %h", j, k, sig, seq[j][k]); end
            end
            next_cycle();
            checks++;
            if (sig !== SIG_FETCH) begin errors++; $display("FAIL jump%0d_refetch: got %h exp %h", j, sig, SIG_FETCH); end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3] = '{7'b0000000, 7'b0000011, 7'b1100011};
        logic [2:0] f3s [3] = '{3'b000, 3'b000, 3'b010};
        for (int i = 0; i < 3; i++) begin
            pulse_reset();
            fetch_decode(ops[i], f3s[i], 1'b0);
            next_cycle();
            checks++;
            if ({sig, trap, trap_cause} !== {19'd0, 3'b101}) begin
                errors++; $display("FAIL illegal%0d_enter: got %h/%b exp 0/101", i, sig, {trap, trap_cause});
            end
            for (int c = 0; c < 20; c++) begin
                mem_ready = 1'($urandom_range(1));
                next_cycle();
                checks++;
                if ({sig, trap, trap_cause} !== {19'd0, 3'b101}) begin
                    errors++; $display("FAIL illegal%0d_hold%0d: got %h/%b exp 0/101", i, c, sig, {trap, trap_cause});
                end
            end
            pulse_reset();
            checks++;
            if ({sig, trap, trap_cause} !== {SIG_FETCH, 3'b000}) begin
                errors++; $display("FAIL illegal%0d_reset: got %h/%b exp %h/000", i, sig, {trap, trap_cause}, SIG_FETCH);
            end
        end
    endtask

    task automatic test_timeout();
        // One short of the limit, then ready: must not trap.
        pulse_reset();
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int c = 0; c < 14; c++) next_cycle();
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({sig, trap} !== {SIG_FETCH_RDY, 1'b0}) begin
            errors++; $display("FAIL timeout_boundary: got %h/%b exp %h/0", sig, trap, SIG_FETCH_RDY);
        end
        next_cycle();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (sig !== SIG_DECODE) begin errors++; $display("FAIL timeout_boundary_decode: got %h exp %h", sig, SIG_DECODE); end
        pulse_reset();
        for (int c = 0; c < 15; c++) begin
            checks++;
            if (sig !== SIG_FETCH) begin errors++; $display("FAIL timeout_wait%0d: got %h exp %h", c, sig, SIG_FETCH); end
            next_cycle();
        end
        checks++;
        if ({sig, trap, trap_cause} !== {19'd0, 3'b110}) begin
            errors++; $display("FAIL timeout_trap: got %h/%b exp 0/110", sig, {trap, trap_cause});
        end
    endtask

    task automatic test_memwrite_reset();
        pulse_reset();
        fetch_decode(7'b0100011, 3'b010, 1'b0);
        next_cycle();
        checks++;
        if (sig !== SIG_MEMADR_SW) begin errors++; $display("FAIL sw_memadr: got %h exp %h", sig, SIG_MEMADR_SW); end
        next_cycle();
        checks++;
        if (sig !== SIG_MEMWRITE) begin errors++; $display("FAIL sw_memwrite: got %h exp %h", sig, SIG_MEMWRITE); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (sig !== SIG_FETCH_RST) begin errors++; $display("FAIL sw_async_reset: got %h exp %h", sig, SIG_FETCH_RST); end
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if ({sig, trap} !== {SIG_FETCH, 1'b0}) begin errors++; $display("FAIL sw_release: got %h/%b exp %h/0", sig, trap, SIG_FETCH); end
        next_cycle();
        checks++;
        if (sig !== SIG_FETCH) begin errors++; $display("FAIL sw_after_release: got %h exp %h", sig, SIG_FETCH); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_branch();
        test_jumps();
        test_illegal();
        test_timeout();
        test_memwrite_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
